lcd_redraw_sched: RTL
=====================

// Module: lcd_redraw_sched
// PURPOSE
//  Frame scheduler and LCD-bus owner for the LCD controller. Takes redraw control
//  (strobe, enable, fps delay, framebuffer address) from the CSR block and runs each frame.
//  Per frame: issue the memory-write command on the 8080-style bus, launch the
//  framebuffer DMA engine, wait for it to finish, then pace the next frame.
//  Muxes the LCD bus between CPU direct-drive (CSR bits) and the scheduler/DMA path.
// PARAMETERS
//  DATA_W      16        LCD bus / pixel width
//  ADDR_W      32        framebuffer byte address width
//  TICK_DIV    50000     clk cycles per fps_delay tick (1 ms @ 50 MHz); >=2
//  MEM_WR_CMD  16'h002C  controller "memory write" command word
//  WR_PULSE    2         WR# low cycles for command write; >=1
// PORTS
//  clk_i         in   1       system clock
//  rst_i         in   1       sync reset, active-high
//  redraw_stb_i  in   1       one-cycle request: draw one frame
//  redraw_en_i   in   1       level: continuous redraw
//  fps_delay_i   in   16      inter-frame gap in ticks; 0 = back-to-back
//  dma_addr_i    in   ADDR_W  framebuffer base
//  cpu_data_i    in   DATA_W  CPU direct-drive bus data
//  cpu_wr_i      in   1       CPU WR# level
//  cpu_rd_i      in   1       CPU RD# level
//  cpu_rs_i      in   1       CPU RS level
//  dma_start_o   out  1       one-cycle start pulse to DMA engine
//  dma_addr_o    out  ADDR_W  frame base, stable from dma_start_o to dma_done_i
//  dma_done_i    in   1       one-cycle pulse: last pixel written
//  dma_data_i    in   DATA_W  pixel data from DMA engine
//  dma_wr_i      in   1       WR# level from DMA engine
//  lcd_data_o    out  DATA_W  LCD bus data (registered)
//  lcd_wr_o      out  1       WR#, active-low (registered)
//  lcd_rd_o      out  1       RD#, active-low (registered)
//  lcd_rs_o      out  1       RS: 0 = command, 1 = data (registered)
//  dma_busy_o    out  1       1 in every state except IDLE
// BEHAVIOUR
//  Reset values: state IDLE, dma_start_o=0, dma_addr_o=0, dma_busy_o=0, lcd_data_o=0,
//   lcd_wr_o=1, lcd_rd_o=1, lcd_rs_o=1, pending=0, counters=0.
//  States: IDLE, CMD_SETUP (1 cyc), CMD_WR (WR_PULSE cyc), CMD_HOLD (1 cyc),
//   DMA_START (1 cyc), DMA_RUN, FPS_WAIT.
//  IDLE -> CMD_SETUP when redraw_stb_i | redraw_en_i | pending. Entry clears pending
//   and latches dma_addr_i into dma_addr_o, held for the whole frame.
//  CMD_*: bus = {rs=0, data=MEM_WR_CMD, rd=1}. wr=0 only in CMD_WR, wr=1 in SETUP/HOLD.
//  DMA_START: dma_start_o=1 for exactly this cycle -> DMA_RUN.
//  DMA_RUN: bus = {rs=1, data=dma_data_i, wr=dma_wr_i, rd=1}. Exit on dma_done_i:
//   pending=1                   -> CMD_SETUP (fps delay skipped)
//   redraw_en_i & fps_delay!=0  -> FPS_WAIT
//   redraw_en_i & fps_delay==0  -> CMD_SETUP
//   else                        -> IDLE
//  FPS_WAIT: down-counter loaded with fps_delay_i on entry; the prescaler restarts at 0.
//   Decrement once per TICK_DIV clocks. Exit at 0 -> CMD_SETUP.
//   redraw_en_i=0 here -> IDLE next cycle, or CMD_SETUP if pending.
//  IDLE and FPS_WAIT: bus = CPU inputs (data/wr/rd/rs passthrough).
//  All bus outputs are registered, so there is 1 cycle latency from source to pin.
//  redraw_stb_i outside IDLE sets pending (1-deep; extra strobes merge).
//   A strobe in the same cycle as the IDLE exit is consumed by that exit, not pended.
//  dma_done_i outside DMA_RUN is ignored. fps_delay_i changes take effect at next FPS_WAIT entry.
//  Reset mid-frame: next cycle in IDLE with reset values; DMA engine shares rst_i.
//  Frame latency: a strobe in IDLE at cycle N gives dma_start_o=1 at cycle N+WR_PULSE+3.
// STRUCTURE
//  lcd_sched_pkg: state_t enum; lcd_bus_t struct {data, wr, rd, rs};
//   MEM_WR_CMD default constant.
//  Sub-module lcd_tick_timer: prescaler + 16-bit down-counter.
//   Ports: load, load value, tick enable, zero flag.
//  Top: FSM, pending flag, address latch, registered bus mux.
// TESTING
//  T1 reset: rst_i for 2 cycles mid-DMA_RUN -> IDLE, dma_start_o=0, wr/rd/rs=1/1/1, dma_busy_o=0.
//  T2 single frame: WR_PULSE=2, dma_addr_i=32'h1000_0000, stb at cycle 10 ->
//   wr=0 with rs=0, data=16'h002C on bus at cycles 12-13;
//   dma_start_o=1 at cycle 15, dma_addr_o=32'h1000_0000; done -> IDLE, busy=0.
//  T3 continuous: TICK_DIV=4, fps_delay=3, en=1, done -> next dma_start_o 12+WR_PULSE+3 cycles
//   after FPS_WAIT entry (+/-1, check exact); fps_delay=0 -> FPS_WAIT never entered.
//  T4 pending: 3 strobes during DMA_RUN, en=0 -> exactly one extra frame, then IDLE.
//  T5 ownership: in IDLE drive cpu_data=16'hA5A5 with wr toggling -> mirrored 1 cycle later;
//   in DMA_RUN cpu inputs have no effect and the dma_* inputs are mirrored.
//  T6 abort wait: drop redraw_en_i during FPS_WAIT -> IDLE next cycle, no dma_start_o;
//   stray dma_done_i in IDLE -> no state change.

Source files
------------

// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD redraw scheduler.
//  state_t    : frame scheduler FSM states
//  lcd_bus_t  : one snapshot of the 8080-style LCD bus {data, wr#, rd#, rs}
//  cmd_bus()  : builds the bus word used while a command is on the pins
package lcd_sched_pkg;

    localparam int                    LCD_DATA_W     = 16;
    localparam logic [LCD_DATA_W-1:0] MEM_WR_CMD_DEF = 16'h002C;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD_SETUP = 3'd1,
        ST_CMD_WR    = 3'd2,
        ST_CMD_HOLD  = 3'd3,
        ST_DMA_START = 3'd4,
        ST_DMA_RUN   = 3'd5,
        ST_FPS_WAIT  = 3'd6
    } state_t;

    typedef struct packed {
        logic [LCD_DATA_W-1:0] data;
        logic                  wr;
        logic                  rd;
        logic                  rs;
    } lcd_bus_t;

    // Command phase: RS low selects the command register, RD# stays idle.
    function automatic lcd_bus_t cmd_bus(input logic [LCD_DATA_W-1:0] cmd,
                                         input logic                  wr_n);
        lcd_bus_t b;
        b.data = cmd;
        b.wr   = wr_n;
        b.rd   = 1'b1;
        b.rs   = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/lcd_redraw_sched_if.sv
// Bus bundle between the redraw scheduler, the framebuffer DMA engine and
// the LCD pins.
//  master : scheduler side (drives DMA start/address and the LCD pins)
//  slave  : environment side (DMA engine + pins)
interface lcd_redraw_sched_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32
);
    logic              dma_start_o;
    logic [ADDR_W-1:0] dma_addr_o;
    logic              dma_done_i;
    logic [DATA_W-1:0] dma_data_i;
    logic              dma_wr_i;
    logic [DATA_W-1:0] lcd_data_o;
    logic              lcd_wr_o;
    logic              lcd_rd_o;
    logic              lcd_rs_o;

    modport master (
        output dma_start_o, dma_addr_o, lcd_data_o, lcd_wr_o, lcd_rd_o, lcd_rs_o,
        input  dma_done_i, dma_data_i, dma_wr_i
    );

    modport slave (
        input  dma_start_o, dma_addr_o, lcd_data_o, lcd_wr_o, lcd_rd_o, lcd_rs_o,
        output dma_done_i, dma_data_i, dma_wr_i
    );
endinterface

// File: rtl/lcd_tick_timer.sv
// Inter-frame gap timer: a prescaler that wraps every TICK_DIV clocks and a
// 16-bit down-counter decremented once per prescaler wrap.
//  clk_i, rst_i  : clock, synchronous active-high reset
//  load_i        : load counter with load_val_i and restart the prescaler at 0
//  load_val_i    : gap length in ticks
//  tick_en_i     : advance prescaler/counter while high
//  zero_o        : counter has reached 0
module lcd_tick_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        tick_en_i,
    output logic        zero_o
);
    localparam int               PRE_W   = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [15:0]      cnt_q, cnt_d;

    // Next-state for prescaler and down-counter; the counter saturates at 0.
    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (load_i) begin
            pre_d = '0;
            cnt_d = load_val_i;
        end else if (tick_en_i) begin
            if (pre_q == PRE_MAX) begin
                pre_d = '0;
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end else begin
            pre_d = pre_q;
            cnt_d = cnt_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q <= '0;
            cnt_q <= 16'd0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 16'd0);

endmodule

// File: rtl/lcd_redraw_sched.sv
// Frame scheduler and LCD-bus owner. Each frame: put the memory-write command
// on the 8080 bus, kick the framebuffer DMA engine, wait for its done pulse,
// then either stop, pace the next frame with the tick timer, or start again.
// Outside a frame the LCD pins follow the CPU direct-drive inputs.
//  clk_i, rst_i          : clock, synchronous active-high reset
//  redraw_stb_i/_en_i    : single-frame request / continuous redraw level
//  fps_delay_i           : inter-frame gap in ticks (0 = back-to-back)
//  dma_addr_i            : framebuffer base, latched at frame start
//  cpu_data/wr/rd/rs_i   : CPU direct-drive of the LCD bus
//  bus                   : DMA handshake + registered LCD pins
//  dma_busy_o            : high whenever the scheduler is not idle
module lcd_redraw_sched
    import lcd_sched_pkg::*;
#(
    parameter int                    DATA_W     = 16,
    parameter int                    ADDR_W     = 32,
    parameter int                    TICK_DIV   = 50000,
    parameter logic [LCD_DATA_W-1:0] MEM_WR_CMD = MEM_WR_CMD_DEF,
    parameter int                    WR_PULSE   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              redraw_stb_i,
    input  logic              redraw_en_i,
    input  logic [15:0]       fps_delay_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              cpu_wr_i,
    input  logic              cpu_rd_i,
    input  logic              cpu_rs_i,
    lcd_redraw_sched_if.master bus,
    output logic              dma_busy_o
);
    localparam int                  WR_CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
    localparam logic [WR_CNT_W-1:0] WR_LAST  = WR_CNT_W'(WR_PULSE - 1);
    localparam lcd_bus_t            BUS_RST  = '{data: '0, wr: 1'b1, rd: 1'b1, rs: 1'b1};

    state_t              state_q, state_d;
    logic                pending_q, pending_d;
    logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    lcd_bus_t            bus_q, bus_d;
    logic                start_q, busy_q;
    logic                tmr_load_s, tmr_en_s, tmr_zero_s;

    assign tmr_en_s = (state_q == ST_FPS_WAIT);

    lcd_tick_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load_s),
        .load_val_i (fps_delay_i),
        .tick_en_i  (tmr_en_s),
        .zero_o     (tmr_zero_s)
    );

    // Next state, pending strobe flag, command pulse counter and address latch.
    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        addr_d     = addr_q;
        tmr_load_s = 1'b0;
        // Strobes that arrive mid-frame collapse into one queued frame.
        if (redraw_stb_i && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (redraw_stb_i || redraw_en_i || pending_q) state_d = ST_CMD_SETUP;
                else                                          state_d = ST_IDLE;
            end
            ST_CMD_SETUP: begin
                state_d  = ST_CMD_WR;
                wr_cnt_d = '0;
            end
            ST_CMD_WR: begin
                if (wr_cnt_q == WR_LAST) begin
                    state_d = ST_CMD_HOLD;
                end else begin
                    wr_cnt_d = wr_cnt_q + WR_CNT_W'(1);
                end
            end
            ST_CMD_HOLD:  state_d = ST_DMA_START;
            ST_DMA_START: state_d = ST_DMA_RUN;
            ST_DMA_RUN: begin
                if (bus.dma_done_i) begin
                    if (pending_q) begin
                        state_d = ST_CMD_SETUP;
                    end else if (redraw_en_i && (fps_delay_i != 16'd0)) begin
                        state_d    = ST_FPS_WAIT;
                        tmr_load_s = 1'b1;
                    end else if (redraw_en_i) begin
                        state_d = ST_CMD_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DMA_RUN;
                end
            end
            ST_FPS_WAIT: begin
                if (!redraw_en_i) state_d = pending_q ? ST_CMD_SETUP : ST_IDLE;
                else if (tmr_zero_s) state_d = ST_CMD_SETUP;
                else state_d = ST_FPS_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
        // Every frame start consumes the pending request (including a strobe
        // in this same cycle) and captures the framebuffer base for the frame.
        if ((state_d == ST_CMD_SETUP) && (state_q != ST_CMD_SETUP)) begin
            pending_d = 1'b0;
            addr_d    = dma_addr_i;
        end else begin
            addr_d = addr_d;
        end
    end

    // Bus mux keyed on the next state so the pins change together with the state.
    always_comb begin
        case (state_d)
            ST_IDLE, ST_FPS_WAIT:
                bus_d = '{data: cpu_data_i, wr: cpu_wr_i, rd: cpu_rd_i, rs: cpu_rs_i};
            ST_CMD_SETUP, ST_CMD_HOLD, ST_DMA_START:
                bus_d = cmd_bus(MEM_WR_CMD, 1'b1);
            ST_CMD_WR:
                bus_d = cmd_bus(MEM_WR_CMD, 1'b0);
            ST_DMA_RUN:
                bus_d = '{data: bus.dma_data_i, wr: bus.dma_wr_i, rd: 1'b1, rs: 1'b1};
            default:
                bus_d = BUS_RST;
        endcase
    end

    // FSM and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            wr_cnt_q  <= '0;
            addr_q    <= '0;
            bus_q     <= BUS_RST;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wr_cnt_q  <= wr_cnt_d;
            addr_q    <= addr_d;
            bus_q     <= bus_d;
            start_q   <= (state_d == ST_DMA_START);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign bus.dma_start_o = start_q;
    assign bus.dma_addr_o  = addr_q;
    assign bus.lcd_data_o  = bus_q.data;
    assign bus.lcd_wr_o    = bus_q.wr;
    assign bus.lcd_rd_o    = bus_q.rd;
    assign bus.lcd_rs_o    = bus_q.rs;
    assign dma_busy_o      = busy_q;

endmodule
